pc_branch_unit: RTL and testbench

//   Owns the program counter of the single-cycle miniRV core; the consumer end of the ALU

---
 rtl/pc_branch_unit_pkg.sv | 24 ++
 rtl/pc_branch_unit_cond.sv | 32 +++
 rtl/pc_branch_unit.sv | 90 +++++++++
 tb/tb_pc_branch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_branch_unit_pkg.sv
// Shared branch-class codes and helpers for the miniRV PC/branch unit.
// The control decoder emits the same 3-bit codes on br_type.
package pc_branch_unit_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_JAL  = 3'd5,
    BR_JALR = 3'd6,
    BR_RSV  = 3'd7
  } br_type_e;

  function automatic logic is_cond_br(input logic [2:0] t);
    return (t == BR_BEQ) || (t == BR_BNE) || (t == BR_BLT) || (t == BR_BGE);
  endfunction

  function automatic logic is_jump(input logic [2:0] t);
    return (t == BR_JAL) || (t == BR_JALR);
  endfunction

endpackage

// File: rtl/pc_branch_unit_cond.sv
// Branch condition resolution from the ALU SUB flags (rs1 - rs2).
// Signed less-than is rebuilt from the operand sign bits since the ALU has no overflow flag.
module branch_cond
  import pc_branch_unit_pkg::*;
(
  input  logic [2:0] br_type,
  input  logic       zero,
  input  logic       sgn,
  input  logic       rs1_msb,
  input  logic       rs2_msb,
  output logic       cond
);

  logic lt;

  // Differing signs decide the order outright; equal signs cannot overflow SUB.
  assign lt = (rs1_msb != rs2_msb) ? rs1_msb : sgn;

  always_comb begin
    cond = 1'b0;
    case (br_type)
      BR_BEQ:  cond = zero;
      BR_BNE:  cond = ~zero;
      BR_BLT:  cond = lt;
      BR_BGE:  cond = ~lt;
      BR_JAL:  cond = 1'b1;
      BR_JALR: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter owner for the single-cycle miniRV core: resolves branches,
// registers the next PC and keeps sticky misalign plus saturating debug counters.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       br_type,
  input  logic             zero,
  input  logic             sgn,
  input  logic             rs1_msb,
  input  logic             rs2_msb,
  input  logic [31:0]      imm,
  input  logic [31:0]      alu_c,
  output logic [31:0]      pc,
  output logic [31:0]      pc4,
  output logic             taken,
  output logic             misalign,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] jmp_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] jmp_cnt_q, jmp_cnt_d;
  logic             cond;
  logic [31:0]      target;
  logic [31:0]      npc;

  branch_cond u_cond (
    .br_type (br_type),
    .zero    (zero),
    .sgn     (sgn),
    .rs1_msb (rs1_msb),
    .rs2_msb (rs2_msb),
    .cond    (cond)
  );

  assign pc4    = pc_q + 32'd4;
  assign taken  = cond;
  assign target = (br_type == BR_JALR) ? {alu_c[31:1], 1'b0} : (pc_q + imm);
  assign npc    = taken ? target : pc4;

  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    br_cnt_d   = br_cnt_q;
    jmp_cnt_d  = jmp_cnt_q;
    if (!stall) begin
      // A misaligned redirect freezes the PC on the offending instruction.
      if (taken && (target[1:0] != 2'b00)) begin
        misalign_d = 1'b1;
      end else begin
        pc_d = npc;
        if (taken && is_cond_br(br_type) && (br_cnt_q != CNT_MAX))
          br_cnt_d = br_cnt_q + CNT_ONE;
        if (is_jump(br_type) && (jmp_cnt_q != CNT_MAX))
          jmp_cnt_d = jmp_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      br_cnt_q   <= '0;
      jmp_cnt_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      br_cnt_q   <= br_cnt_d;
      jmp_cnt_q  <= jmp_cnt_d;
    end
  end

  assign pc       = pc_q;
  assign misalign = misalign_q;
  assign br_cnt   = br_cnt_q;
  assign jmp_cnt  = jmp_cnt_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: random instruction stream against a signed-compare model,
// plus directed scenarios with literal expectations.
module tb_pc_branch_unit;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             stall = 1'b0;
  logic [2:0]       br_type = 3'd0;
  logic             zero = 1'b0, sgn = 1'b0, rs1_msb = 1'b0, rs2_msb = 1'b0;
  logic [31:0]      imm = '0, alu_c = '0;
  logic [31:0]      pc, pc4;
  logic             taken, misalign;
  logic [CNT_W-1:0] br_cnt, jmp_cnt;

  // Operands behind the flags; the model reasons on these directly.
  logic [31:0] s_rs1 = '0, s_rs2 = '0;

  int total = 0;
  int bad = 0;

  // Model state
  logic [31:0] m_pc;
  logic        m_mis;
  int          m_br, m_jmp;

  pc_branch_unit #(.RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_type(br_type),
    .zero(zero), .sgn(sgn), .rs1_msb(rs1_msb), .rs2_msb(rs2_msb),
    .imm(imm), .alu_c(alu_c), .pc(pc), .pc4(pc4), .taken(taken),
    .misalign(misalign), .br_cnt(br_cnt), .jmp_cnt(jmp_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: decision taken straight from the architectural meaning of each branch.
  function automatic logic m_taken(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return $signed(a) < $signed(b);
      3'd4: return $signed(a) >= $signed(b);
      3'd5, 3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(input logic [2:0] t, input logic [31:0] p,
                                           input logic [31:0] im, input logic [31:0] c);
    if (t == 3'd6) return c & ~32'h1;
    return p + im;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'h0; m_mis = 1'b0; m_br = 0; m_jmp = 0;
    end else if (!stall) begin
      logic        t;
      logic [31:0] tg;
      t  = m_taken(br_type, s_rs1, s_rs2);
      tg = m_target(br_type, m_pc, imm, alu_c);
      if (t && (tg % 4 != 0)) begin
        m_mis = 1'b1;
      end else begin
        m_pc = t ? tg : m_pc + 4;
        if (t && br_type >= 3'd1 && br_type <= 3'd4) m_br = (m_br < CNT_MAX) ? m_br + 1 : m_br;
        if (br_type == 3'd5 || br_type == 3'd6) m_jmp = (m_jmp < CNT_MAX) ? m_jmp + 1 : m_jmp;
      end
    end
  end

  // Single compare process, mid-cycle.
  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("pc4", pc4, m_pc + 32'd4);
    chk("taken", {31'b0, taken}, {31'b0, m_taken(br_type, s_rs1, s_rs2)});
    chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
    chk("br_cnt", {28'b0, br_cnt}, m_br);
    chk("jmp_cnt", {28'b0, jmp_cnt}, m_jmp);
  end

  // driver tasks
  task automatic set_in(input logic st, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] im, input logic [31:0] c);
    logic [31:0] d;
    d = a - b;
    stall = st; br_type = t; s_rs1 = a; s_rs2 = b;
    zero = (d == 32'h0); sgn = d[31]; rs1_msb = a[31]; rs2_msb = b[31];
    imm = im; alu_c = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic st, input logic [2:0] t, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] im, input logic [31:0] c);
    set_in(st, t, a, b, im, c);
    tick();
  endtask

  task automatic do_reset();
    set_in(1'b0, 3'd0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b, im, c;
    int j0;

    do_reset();
    chk("rst_pc", pc, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 3'd0, 0, 0, 0, 0);
      chk("seq_pc", pc, 32'(4 * i));
    end

    // Random instruction stream
    for (int i = 0; i < 400; i++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      im = 32'(($urandom_range(0, 63) - 32) * 4);
      if ($urandom_range(0, 15) == 0) im = im + 32'd2;
      c  = $urandom & ~32'h3;
      if ($urandom_range(0, 15) == 0) c = c | 32'h2;
      if ($urandom_range(0, 1) == 0) c = c | 32'h1;
      step($urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)), a, b, im, c);
    end

    // Asynchronous reset mid-stall
    step(0, 3'd6, 0, 0, 0, 32'h41);
    chk("pre_rst_pc", pc, 32'h40);
    set_in(1'b1, 3'd5, 0, 0, 32'h10, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_mis", {31'b0, misalign}, 32'h0);
    chk("async_br", {28'b0, br_cnt}, 32'h0);
    chk("async_jmp", {28'b0, jmp_cnt}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step(0, 3'd0, 0, 0, 0, 0);
      chk("rel_pc", pc, 32'(4 * i));
    end

    // BEQ taken / not taken from 0x100
    step(0, 3'd6, 0, 0, 0, 32'h100);
    step(0, 3'd1, 5, 5, 32'hFFFF_FFF8, 0);
    chk("beq_t_pc", pc, 32'hF8);
    chk("beq_t_model", m_pc, 32'hF8);
    chk("beq_t_br", {28'b0, br_cnt}, 32'h1);
    step(0, 3'd6, 0, 0, 0, 32'h100);
    step(0, 3'd1, 5, 6, 32'hFFFF_FFF8, 0);
    chk("beq_n_pc", pc, 32'h104);
    chk("beq_n_br", {28'b0, br_cnt}, 32'h1);

    // Signed compare with SUB overflow
    set_in(0, 3'd3, 32'h8000_0000, 32'h1, 32'h10, 0);
    #1 chk("blt_taken", {31'b0, taken}, 32'h1);
    chk("blt_sgn", {31'b0, sgn}, 32'h0);
    tick();
    chk("blt_pc", pc, 32'h114);
    set_in(0, 3'd4, 32'h8000_0000, 32'h1, 32'h10, 0);
    #1 chk("bge_taken", {31'b0, taken}, 32'h0);
    tick();
    chk("bge_pc", pc, 32'h118);

    // JALR alignment and sticky misalign
    j0 = int'(jmp_cnt);
    step(0, 3'd6, 0, 0, 0, 32'h2001);
    chk("jalr_pc", pc, 32'h2000);
    chk("jalr_jmp", {28'b0, jmp_cnt}, 32'(j0 + 1));
    step(0, 3'd5, 0, 0, 32'h6, 0);
    chk("mis_pc", pc, 32'h2000);
    chk("mis_set", {31'b0, misalign}, 32'h1);
    chk("mis_jmp", {28'b0, jmp_cnt}, 32'(j0 + 1));
    step(0, 3'd5, 0, 0, 32'h8, 0);
    chk("mis_pc2", pc, 32'h2008);
    chk("mis_sticky", {31'b0, misalign}, 32'h1);

    // Stall holds everything; release applies the jump once
    j0 = int'(jmp_cnt);
    for (int i = 0; i < 3; i++) begin
      step(1, 3'd5, 0, 0, 32'h10, 0);
      chk("stall_pc", pc, 32'h2008);
      chk("stall_jmp", {28'b0, jmp_cnt}, 32'(j0));
    end
    step(0, 3'd5, 0, 0, 32'h10, 0);
    chk("unstall_pc", pc, 32'h2018);
    step(0, 3'd0, 0, 0, 32'h10, 0);
    chk("once_pc", pc, 32'h201C);

    // Counter saturation and PC wrap
    do_reset();
    for (int i = 0; i < CNT_MAX + 2; i++) step(0, 3'd2, 1, 2, 32'h4, 0);
    chk("br_sat", {28'b0, br_cnt}, 32'hF);
    for (int i = 0; i < CNT_MAX + 2; i++) step(0, 3'd5, 0, 0, 32'h4, 0);
    chk("jmp_sat", {28'b0, jmp_cnt}, 32'hF);
    chk("br_hold", {28'b0, br_cnt}, 32'hF);
    step(0, 3'd6, 0, 0, 0, 32'hFFFF_FFFD);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4, 32'h0);
    step(0, 3'd0, 0, 0, 0, 0);
    chk("wrap_pc", pc, 32'h0);
    step(0, 3'd7, 3, 3, 32'h40, 32'h80);
    chk("rsv_pc", pc, 32'h4);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
